shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_if.sv | 25 ++
 rtl/shift_sequencer.sv | 134 +++++++++++++
 tb/tb_shift_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle for shift_sequencer; master drives requests,
// slave (the sequencer) drives the serial stream and status.
interface shift_sequencer_if #(
  parameter int NBITS_DATA = 4
);
  logic                          start;
  logic [NBITS_DATA-1:0]         data_in;
  logic                          fill_bit;
  logic [NBITS_DATA-1:0]         data_out;
  logic                          tx_bit;
  logic                          tx_valid;
  logic                          busy;
  logic                          done;
  logic [$clog2(NBITS_DATA):0]   bit_cnt;

  modport master (
    output start, data_in, fill_bit,
    input  data_out, tx_bit, tx_valid, busy, done, bit_cnt
  );

  modport slave (
    input  start, data_in, fill_bit,
    output data_out, tx_bit, tx_valid, busy, done, bit_cnt
  );
endinterface

// File: rtl/shift_sequencer.sv
// Loads a parallel word and shifts it out serially, LSB first, refilling from fill_bit.
// Define SEQ_PARITY_EN to append an even-parity bit after the data bits.
module shift_sequencer #(
  parameter int NBITS_DATA = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  shift_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(NBITS_DATA) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS_DATA - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
`ifdef SEQ_PARITY_EN
    PAR   = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t                state_r;
  state_t                next_state;
  logic [NBITS_DATA-1:0] data_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  tx_bit_s;
  logic                  tx_valid_s;
  logic                  busy_s;
  logic                  done_s;

`ifdef SEQ_PARITY_EN
  logic                  parity_r;

  function automatic logic parity_of(input logic [NBITS_DATA-1:0] word);
    return ^word;
  endfunction
`endif

  // State register
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // Next-state and status decode; all outputs follow the registered state
  always_comb begin
    next_state = state_r;
    tx_valid_s = 1'b0;
    tx_bit_s   = 1'b0;
    busy_s     = 1'b1;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (bus.start) begin
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        next_state = SHIFT;
      end
      SHIFT: begin
        tx_valid_s = 1'b1;
        tx_bit_s   = data_r[0];
        if (cnt_r == LAST_CNT) begin
`ifdef SEQ_PARITY_EN
          next_state = PAR;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = SHIFT;
        end
      end
`ifdef SEQ_PARITY_EN
      PAR: begin
        tx_valid_s = 1'b1;
        tx_bit_s   = parity_r;
        next_state = DONE;
      end
`endif
      DONE: begin
        done_s     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        busy_s     = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  // Shift register, bit counter and parity capture
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      data_r   <= {NBITS_DATA{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
`ifdef SEQ_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        LOAD: begin
          data_r   <= bus.data_in;
          cnt_r    <= {CNT_W{1'b0}};
`ifdef SEQ_PARITY_EN
          parity_r <= parity_of(bus.data_in);
`endif
        end
        SHIFT: begin
          data_r <= {bus.fill_bit, data_r[NBITS_DATA-1:1]};
          cnt_r  <= cnt_r + CNT_W'(1);
        end
        default: begin
          data_r <= data_r;
          cnt_r  <= cnt_r;
        end
      endcase
    end
  end

  assign bus.data_out = data_r;
  assign bus.bit_cnt  = cnt_r;
  assign bus.tx_bit   = tx_bit_s;
  assign bus.tx_valid = tx_valid_s;
  assign bus.busy     = busy_s;
  assign bus.done     = done_s;
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized words
// checked cycle by cycle against an arithmetic model of the serial stream.
module tb_shift_sequencer;
  localparam int N  = 4;
  localparam int CW = $clog2(N) + 1;
`ifdef SEQ_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk_2;
  logic reset;
  int   n_checks;
  int   n_fail;

  shift_sequencer_if #(.NBITS_DATA(N)) bus ();

  shift_sequencer #(.NBITS_DATA(N)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Runs one word starting from an IDLE negedge; returns at the IDLE negedge after DONE.
  task automatic run_word(input logic [N-1:0] d, input logic fill, input bit rand_fill,
                          input bit poke_start, input bit hold_start,
                          output logic [N-1:0] tx_seen, output int nvalid);
    logic [N-1:0] model;
    logic         f;
    nvalid    = 0;
    tx_seen   = '0;
    bus.start    = 1'b1;
    bus.data_in  = d;
    bus.fill_bit = fill;
    @(posedge clk_2);
    @(negedge clk_2);
    if (!hold_start) bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", bus.busy); end
    n_checks++; if ({bus.tx_valid, bus.tx_bit, bus.done} !== 3'b000) begin n_fail++; $display("FAIL load_idle_outs: got %b want 000", {bus.tx_valid, bus.tx_bit, bus.done}); end
    if (bus.tx_valid === 1'b1) nvalid++;
    model = d;
    for (int k = 0; k < N; k++) begin
      @(negedge clk_2);
      bus.data_in = N'($urandom);
      if (bus.tx_valid === 1'b1) nvalid++;
      tx_seen[k] = bus.tx_bit;
      n_checks++; if (bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL shift_valid[%0d]: got %b want 1", k, bus.tx_valid); end
      n_checks++; if (bus.tx_bit !== d[k]) begin n_fail++; $display("FAIL shift_tx_bit[%0d]: got %b want %b", k, bus.tx_bit, d[k]); end
      n_checks++; if (bus.bit_cnt !== CW'(k)) begin n_fail++; $display("FAIL shift_bit_cnt[%0d]: got %0d want %0d", k, bus.bit_cnt, k); end
      n_checks++; if (bus.data_out !== model) begin n_fail++; $display("FAIL shift_data_out[%0d]: got %b want %b", k, bus.data_out, model); end
      n_checks++; if ({bus.busy, bus.done} !== 2'b10) begin n_fail++; $display("FAIL shift_status[%0d]: got %b want 10", k, {bus.busy, bus.done}); end
      if (poke_start && k == 1) bus.start = 1'b1;
      f = rand_fill ? 1'($urandom) : fill;
      bus.fill_bit = f;
      model = (model >> 1) | (N'(f) << (N - 1));
    end
`ifdef SEQ_PARITY_EN
    @(negedge clk_2);
    if (bus.tx_valid === 1'b1) nvalid++;
    bus.fill_bit = 1'($urandom);
    n_checks++; if ({bus.tx_valid, bus.tx_bit} !== {1'b1, ^d}) begin n_fail++; $display("FAIL par_bit: got %b want %b", {bus.tx_valid, bus.tx_bit}, {1'b1, ^d}); end
    n_checks++; if (bus.data_out !== model) begin n_fail++; $display("FAIL par_data_out: got %b want %b", bus.data_out, model); end
`endif
    @(negedge clk_2);
    if (bus.tx_valid === 1'b1) nvalid++;
    n_checks++; if ({bus.done, bus.busy, bus.tx_valid, bus.tx_bit} !== 4'b1100) begin n_fail++; $display("FAIL done_outs: got %b want 1100", {bus.done, bus.busy, bus.tx_valid, bus.tx_bit}); end
    n_checks++; if (bus.data_out !== model) begin n_fail++; $display("FAIL done_data_out: got %b want %b", bus.data_out, model); end
    n_checks++; if (bus.bit_cnt !== CW'(N)) begin n_fail++; $display("FAIL done_bit_cnt: got %0d want %0d", bus.bit_cnt, N); end
    bus.fill_bit = 1'($urandom);
    bus.data_in  = N'($urandom);
    @(negedge clk_2);
    if (poke_start) bus.start = 1'b0;
    n_checks++; if ({bus.busy, bus.done, bus.tx_valid} !== 3'b000) begin n_fail++; $display("FAIL idle_after_done: got %b want 000", {bus.busy, bus.done, bus.tx_valid}); end
    n_checks++; if (bus.data_out !== model) begin n_fail++; $display("FAIL idle_hold: got %b want %b", bus.data_out, model); end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.data_in = '0; bus.fill_bit = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if ({bus.data_out, bus.bit_cnt, bus.tx_bit, bus.tx_valid, bus.busy, bus.done} !== '0) begin n_fail++; $display("FAIL reset_state: got %b want 0", {bus.data_out, bus.bit_cnt, bus.tx_bit, bus.tx_valid, bus.busy, bus.done}); end
    @(negedge clk_2);
    @(negedge clk_2);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.data_in  = N'($urandom);
      bus.fill_bit = 1'($urandom);
      @(negedge clk_2);
      n_checks++; if ({bus.busy, bus.done, bus.tx_valid, bus.data_out} !== '0) begin n_fail++; $display("FAIL idle_cycle[%0d]: got %b want 0", c, {bus.busy, bus.done, bus.tx_valid, bus.data_out}); end
    end
  endtask

  task automatic test_single_word();
    logic [N-1:0] seen; int nv;
    run_word(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, seen, nv);
    n_checks++; if (seen !== 4'b1011) begin n_fail++; $display("FAIL single_tx_seq: got %b want 1011", seen); end
    n_checks++; if (bus.data_out !== 4'b0000) begin n_fail++; $display("FAIL single_data_out: got %b want 0000", bus.data_out); end
    n_checks++; if (nv !== N + EXTRA) begin n_fail++; $display("FAIL single_nvalid: got %0d want %0d", nv, N + EXTRA); end
  endtask

  task automatic test_fill();
    logic [N-1:0] seen; int nv;
    run_word(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, seen, nv);
    n_checks++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL fill_tx_seq: got %b want 0000", seen); end
    n_checks++; if (bus.data_out !== 4'b1111) begin n_fail++; $display("FAIL fill_data_out: got %b want 1111", bus.data_out); end
  endtask

  task automatic test_ignored_start();
    logic [N-1:0] seen; int nv;
    run_word(4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, seen, nv);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_2);
      n_checks++; if ({bus.busy, bus.tx_valid, bus.done} !== 3'b000) begin n_fail++; $display("FAIL ignored_start_idle[%0d]: got %b want 000", c, {bus.busy, bus.tx_valid, bus.done}); end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [N-1:0] seen; int nv;
    bus.start = 1'b1; bus.data_in = 4'b1100; bus.fill_bit = 1'b0;
    @(posedge clk_2);
    @(negedge clk_2);
    bus.start = 1'b0;
    repeat (3) @(negedge clk_2);
    n_checks++; if ({bus.data_out, bus.bit_cnt} !== {4'b1100 >> 2, CW'(2)}) begin n_fail++; $display("FAIL mid_before_reset: got %b want %b", {bus.data_out, bus.bit_cnt}, {4'b1100 >> 2, CW'(2)}); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({bus.data_out, bus.bit_cnt, bus.tx_bit, bus.tx_valid, bus.busy, bus.done} !== '0) begin n_fail++; $display("FAIL mid_async_reset: got %b want 0", {bus.data_out, bus.bit_cnt, bus.tx_bit, bus.tx_valid, bus.busy, bus.done}); end
    @(negedge clk_2);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_2);
      n_checks++; if ({bus.done, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL mid_no_done[%0d]: got %b want 00", c, {bus.done, bus.busy}); end
    end
    run_word(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, seen, nv);
    n_checks++; if (seen !== 4'b1100) begin n_fail++; $display("FAIL mid_next_word: got %b want 1100", seen); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] seen; int nv;
    run_word(4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, seen, nv);
    run_word(4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, seen, nv);
    n_checks++; if (seen !== 4'b0101) begin n_fail++; $display("FAIL b2b_second_word: got %b want 0101", seen); end
  endtask

`ifdef SEQ_PARITY_EN
  task automatic test_parity();
    logic [N-1:0] seen; int nv;
    run_word(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, seen, nv);
    n_checks++; if (seen !== 4'b0111) begin n_fail++; $display("FAIL parity_tx_seq: got %b want 0111", seen); end
    n_checks++; if (nv !== 5) begin n_fail++; $display("FAIL parity_nvalid: got %0d want 5", nv); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] seen; logic [N-1:0] d; int nv;
    for (int i = 0; i < 12; i++) begin
      d = N'($urandom);
      run_word(d, 1'($urandom), 1'b1, 1'($urandom), 1'b0, seen, nv);
      n_checks++; if (seen !== d) begin n_fail++; $display("FAIL random_tx_seq[%0d]: got %b want %b", i, seen, d); end
      repeat ($urandom_range(0, 2)) @(negedge clk_2);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    test_reset();
    test_single_word();
    test_fill();
    test_ignored_start();
    test_reset_mid_word();
    test_back_to_back();
`ifdef SEQ_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
